// File: rtl/enemy_spawner_pkg.sv
// Shared types for the enemy spawner: stage encodings (common with the stage
// controller) and the boss life-cycle states.
package enemy_spawner_pkg;

  typedef enum logic [1:0] {
    STAGE_INIT   = 2'b00,
    STAGE_NORMAL = 2'b01,
    STAGE_BOSS   = 2'b10,
    STAGE_CLEAR  = 2'b11
  } stage_t;

  typedef enum logic [1:0] {
    BOSS_IDLE   = 2'b00,
    BOSS_ACTIVE = 2'b01,
    BOSS_DEAD   = 2'b10
  } boss_state_t;

  localparam int HP_W = 4;

endpackage

// File: rtl/enemy_spawner_if.sv
// Bundle between stage controller / sprite-collision logic (master) and the
// enemy spawner (slave).
interface enemy_spawner_if #(
  parameter int FLY_COUNT      = 4,
  parameter int MOSQUITO_COUNT = 12
);
  logic [1:0]                stage_state;
  logic [FLY_COUNT-1:0]      fly_hit;
  logic [MOSQUITO_COUNT-1:0] mosquito_hit;
  logic                      spider_hit;
  logic [FLY_COUNT-1:0]      fly_alive;
  logic [MOSQUITO_COUNT-1:0] mosquito_alive;
  logic [FLY_COUNT-1:0]      fly_release;
  logic [MOSQUITO_COUNT-1:0] mosquito_release;
  logic                      spider_alive;
  logic [3:0]                spider_hp;
  logic                      spawn_busy;

  modport master (
    output stage_state, fly_hit, mosquito_hit, spider_hit,
    input  fly_alive, mosquito_alive, fly_release, mosquito_release,
           spider_alive, spider_hp, spawn_busy
  );

  modport slave (
    input  stage_state, fly_hit, mosquito_hit, spider_hit,
    output fly_alive, mosquito_alive, fly_release, mosquito_release,
           spider_alive, spider_hp, spawn_busy
  );
endinterface

// File: rtl/enemy_spawner_release_timer.sv
// Gap counter plus release index: strobes once every SPAWN_GAP enabled cycles
// until all TOTAL enemies have been released.
module enemy_spawner_release_timer #(
  parameter int TOTAL     = 16,
  parameter int SPAWN_GAP = 12_500_000,
  parameter int IDX_W     = $clog2(TOTAL + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_load,
  output logic             o_release_strobe,
  output logic [IDX_W-1:0] o_release_idx,
  output logic             o_done
);
  localparam int CNT_W = $clog2(SPAWN_GAP);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_last;

  assign w_last           = (r_cnt == CNT_W'(SPAWN_GAP - 1));
  assign o_done           = (r_idx >= IDX_W'(TOTAL));
  assign o_release_strobe = i_enable && !o_done && w_last;
  assign o_release_idx    = r_idx;

  // Load wins over reset: the controller pulses reset during its INIT cycle,
  // and index 0 is released by the load itself.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_cnt <= '0;
      r_idx <= IDX_W'(1);
    end else if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_enable && !o_done) begin
      if (w_last) begin
        r_cnt <= '0;
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/enemy_spawner.sv
// Per-enemy alive/release flags for flies and mosquitoes, plus spider boss
// spawn and hit-point tracking.
module enemy_spawner
  import enemy_spawner_pkg::*;
#(
  parameter int FLY_COUNT      = 4,
  parameter int MOSQUITO_COUNT = 12,
  parameter int SPAWN_GAP      = 12_500_000,
  parameter int SPIDER_HP      = 8
) (
  input logic           clk25,
  input logic           reset_all,
  enemy_spawner_if.slave bus
);
  localparam int TOTAL = FLY_COUNT + MOSQUITO_COUNT;
  localparam int IDX_W = $clog2(TOTAL + 1);

  function automatic logic [HP_W-1:0] hp_sat_dec(input logic [HP_W-1:0] hp);
    return (hp == '0) ? '0 : hp - HP_W'(1);
  endfunction

  stage_t           w_stage;
  logic             w_strobe;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_done;
  logic [TOTAL-1:0] w_hit;
  logic [TOTAL-1:0] w_hit_eff;
  logic [TOTAL-1:0] w_rel_set;
  logic             w_boss_entry;

  logic [TOTAL-1:0] r_alive;
  logic [TOTAL-1:0] r_release;
  logic             r_busy;
  stage_t           r_prev_stage;
  boss_state_t      r_boss_state;
  logic             r_spider_alive;
  logic [HP_W-1:0]  r_spider_hp;

  assign w_stage = stage_t'(bus.stage_state);

  enemy_spawner_release_timer #(
    .TOTAL    (TOTAL),
    .SPAWN_GAP(SPAWN_GAP),
    .IDX_W    (IDX_W)
  ) u_timer (
    .i_clk           (clk25),
    .i_rst           (reset_all),
    .i_enable        (w_stage == STAGE_NORMAL),
    .i_load          (w_stage == STAGE_INIT),
    .o_release_strobe(w_strobe),
    .o_release_idx   (w_idx),
    .o_done          (w_done)
  );

  // Combined vector: flies in the low bits, mosquitoes above, matching release order.
  assign w_hit      = {bus.mosquito_hit, bus.fly_hit};
  assign w_hit_eff  = w_hit & r_release;
  assign w_rel_set  = w_strobe ? (TOTAL'(1) << w_idx) : '0;
  assign w_idx_next = w_strobe ? w_idx + IDX_W'(1) : w_idx;

  // spawn_busy is raised by the wave load so it is already valid in the
  // controller's first NORMAL cycle.
  always_ff @(posedge clk25) begin
    if (w_stage == STAGE_INIT) begin
      r_alive   <= '1;
      r_release <= TOTAL'(1);
      r_busy    <= (TOTAL > 1);
    end else if (reset_all) begin
      r_alive   <= '0;
      r_release <= '0;
      r_busy    <= 1'b0;
    end else if (w_stage != STAGE_CLEAR) begin
      r_alive   <= r_alive & ~w_hit_eff;
      r_release <= (r_release & ~w_hit_eff) | w_rel_set;
      r_busy    <= (w_stage == STAGE_NORMAL) && !w_done && (w_idx_next < IDX_W'(TOTAL));
    end else begin
      r_busy    <= 1'b0;
    end
  end

  always_ff @(posedge clk25) begin
    r_prev_stage <= reset_all ? STAGE_INIT : w_stage;
  end

  assign w_boss_entry = (w_stage == STAGE_BOSS) && (r_prev_stage != STAGE_BOSS);

  always_ff @(posedge clk25) begin
    if (reset_all || (w_stage == STAGE_INIT)) begin
      r_boss_state   <= BOSS_IDLE;
      r_spider_alive <= 1'b0;
      r_spider_hp    <= '0;
    end else if (w_boss_entry) begin
      r_boss_state   <= BOSS_ACTIVE;
      r_spider_alive <= 1'b1;
      r_spider_hp    <= HP_W'(SPIDER_HP);
    end else begin
      case (r_boss_state)
        BOSS_ACTIVE: begin
          if ((w_stage == STAGE_BOSS) && r_spider_alive && bus.spider_hit) begin
            r_spider_hp <= hp_sat_dec(r_spider_hp);
            if (r_spider_hp <= HP_W'(1)) begin
              r_spider_alive <= 1'b0;
              r_boss_state   <= BOSS_DEAD;
            end
          end
        end
        default: begin
          r_boss_state <= r_boss_state;
        end
      endcase
    end
  end

  assign bus.fly_alive        = r_alive[FLY_COUNT-1:0];
  assign bus.mosquito_alive   = r_alive[TOTAL-1:FLY_COUNT];
  assign bus.fly_release      = r_release[FLY_COUNT-1:0];
  assign bus.mosquito_release = r_release[TOTAL-1:FLY_COUNT];
  assign bus.spider_alive     = r_spider_alive;
  assign bus.spider_hp        = r_spider_hp;
  assign bus.spawn_busy       = r_busy;
endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner with FLY_COUNT=2, MOSQUITO_COUNT=2,
// SPAWN_GAP=4, SPIDER_HP=3.
module tb_enemy_spawner;
  logic clk;
  logic reset_all;
  int   n_chk;
  int   n_err;

  enemy_spawner_if #(.FLY_COUNT(2), .MOSQUITO_COUNT(2)) bus ();

  enemy_spawner #(
    .FLY_COUNT     (2),
    .MOSQUITO_COUNT(2),
    .SPAWN_GAP     (4),
    .SPIDER_HP     (3)
  ) dut (
    .clk25    (clk),
    .reset_all(reset_all),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_all        = 1'b1;
    bus.stage_state  = 2'b11;
    bus.fly_hit      = '0;
    bus.mosquito_hit = '0;
    bus.spider_hit   = 1'b0;
    step(1);
    check("rst fly_alive", 16'(bus.fly_alive), 16'h0);
    check("rst mosq_alive", 16'(bus.mosquito_alive), 16'h0);
    check("rst fly_rel", 16'(bus.fly_release), 16'h0);
    check("rst spider_hp", 16'(bus.spider_hp), 16'h0);
    check("rst busy", 16'(bus.spawn_busy), 16'h0);

    // Wave load with reset pulse in the INIT cycle
    bus.stage_state = 2'b00;
    step(1);
    reset_all = 1'b0;
    bus.stage_state = 2'b01;
    check("load fly_alive", 16'(bus.fly_alive), 16'h3);
    check("load mosq_alive", 16'(bus.mosquito_alive), 16'h3);
    check("load fly_rel", 16'(bus.fly_release), 16'h1);
    check("load mosq_rel", 16'(bus.mosquito_release), 16'h0);
    check("load busy", 16'(bus.spawn_busy), 16'h1);
    bus.fly_hit = 2'b10;
    step(1);
    bus.fly_hit = 2'b00;
    check("unrel hit ignored", 16'(bus.fly_alive), 16'h3);
    step(2);
    check("c4 fly_rel", 16'(bus.fly_release), 16'h1);
    step(1);
    check("c5 fly_rel", 16'(bus.fly_release), 16'h3);
    step(1);
    bus.fly_hit = 2'b10;
    step(1);
    bus.fly_hit = 2'b00;
    check("hit fly_alive", 16'(bus.fly_alive), 16'h1);
    check("hit fly_rel", 16'(bus.fly_release), 16'h1);
    step(1);
    check("c8 mosq_rel", 16'(bus.mosquito_release), 16'h0);
    step(1);
    check("c9 mosq_rel", 16'(bus.mosquito_release), 16'h1);
    step(3);
    check("c12 mosq_rel", 16'(bus.mosquito_release), 16'h1);
    check("c12 busy", 16'(bus.spawn_busy), 16'h1);
    step(1);
    check("c13 mosq_rel", 16'(bus.mosquito_release), 16'h3);
    check("c13 busy", 16'(bus.spawn_busy), 16'h0);
    bus.mosquito_hit = 2'b11;
    bus.fly_hit      = 2'b10;
    step(1);
    bus.mosquito_hit = 2'b00;
    bus.fly_hit      = 2'b00;
    check("multi hit mosq_alive", 16'(bus.mosquito_alive), 16'h0);
    check("multi hit mosq_rel", 16'(bus.mosquito_release), 16'h0);
    check("dead hit fly_alive", 16'(bus.fly_alive), 16'h1);
    step(4);
    check("saturated fly_rel", 16'(bus.fly_release), 16'h1);
    check("saturated busy", 16'(bus.spawn_busy), 16'h0);

    // Boss spawn with hit held from the entry cycle
    bus.stage_state = 2'b10;
    bus.spider_hit  = 1'b1;
    step(1);
    check("boss spawn alive", 16'(bus.spider_alive), 16'h1);
    check("boss spawn hp", 16'(bus.spider_hp), 16'h3);
    step(1);
    check("boss hp2", 16'(bus.spider_hp), 16'h2);
    step(1);
    check("boss hp1", 16'(bus.spider_hp), 16'h1);
    check("boss hp1 alive", 16'(bus.spider_alive), 16'h1);
    step(1);
    check("boss hp0", 16'(bus.spider_hp), 16'h0);
    check("boss dead", 16'(bus.spider_alive), 16'h0);
    step(2);
    check("boss no wrap", 16'(bus.spider_hp), 16'h0);

    // Re-enter BOSS, then reset mid-boss
    bus.spider_hit  = 1'b0;
    bus.stage_state = 2'b01;
    step(1);
    bus.stage_state = 2'b10;
    step(1);
    check("respawn alive", 16'(bus.spider_alive), 16'h1);
    check("respawn hp", 16'(bus.spider_hp), 16'h3);
    reset_all = 1'b1;
    step(1);
    reset_all = 1'b0;
    bus.stage_state = 2'b11;
    check("midboss rst spider", 16'(bus.spider_alive), 16'h0);
    check("midboss rst hp", 16'(bus.spider_hp), 16'h0);
    check("midboss rst fly", 16'(bus.fly_alive), 16'h0);
    check("midboss rst rel", 16'(bus.fly_release), 16'h0);
    step(2);
    check("clear no spawn", 16'(bus.spider_alive), 16'h0);

    // Round loop: CLEAR -> INIT with reset pulse and an ignored INIT-cycle hit
    bus.stage_state = 2'b00;
    reset_all = 1'b1;
    bus.fly_hit = 2'b11;
    step(1);
    reset_all = 1'b0;
    bus.fly_hit = 2'b00;
    bus.stage_state = 2'b01;
    check("reload fly_alive", 16'(bus.fly_alive), 16'h3);
    check("reload mosq_alive", 16'(bus.mosquito_alive), 16'h3);
    check("reload fly_rel", 16'(bus.fly_release), 16'h1);
    check("reload spider", 16'(bus.spider_alive), 16'h0);
    check("reload busy", 16'(bus.spawn_busy), 16'h1);
    step(3);
    check("reload c4 fly_rel", 16'(bus.fly_release), 16'h1);
    step(1);
    check("reload c5 fly_rel", 16'(bus.fly_release), 16'h3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
